// File: rtl/debounce_switch_ev.sv
// Switch/button conditioner: per-channel synchroniser, sample-rate debounce
// filter, registered level with rise/fall strobes, and a long-press detector.
module debounce_switch_ev #(
  parameter int WIDTH       = 13,
  parameter int N           = 4,
  parameter int RATE        = 125000,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_TICKS  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] hold,
  output logic [WIDTH-1:0] hold_pulse
);

  localparam int PW = (RATE > 1) ? $clog2(RATE) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  logic             tick;
  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;

  // Shared sample-tick prescaler.
  generate
    if (RATE == 1) begin : g_tick_every
      assign tick = 1'b1;
    end else begin : g_prescale
      localparam logic [PW-1:0] PRE_LAST = PW'(RATE - 1);
      logic [PW-1:0] pre_count_reg;

      assign tick = (pre_count_reg == PRE_LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pre_count_reg <= '0;
        end else if (tick) begin
          pre_count_reg <= '0;
        end else begin
          pre_count_reg <= pre_count_reg + PW'(1);
        end
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [N-1:0]           shift_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg  <= '0;
          shift_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], in[gi]};
          if (tick) begin
            shift_reg <= {shift_reg[N-2:0], sync_reg[SYNC_STAGES-1]};
          end
        end
      end

      // Unanimous ones set, unanimous zeros clear, any mix holds.
      assign state_next[gi] = (&shift_reg) | (state_reg[gi] & (|shift_reg));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      rise_reg  <= '0;
      fall_reg  <= '0;
    end else begin
      state_reg <= state_next;
      rise_reg  <= state_next & ~state_reg;
      fall_reg  <= ~state_next & state_reg;
    end
  end

  assign out  = state_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

  generate
    if (HOLD_TICKS > 0) begin : g_hold
      localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
      logic [WIDTH-1:0] hold_now;
      logic [WIDTH-1:0] hold_next;
      logic [WIDTH-1:0] hold_pulse_reg;

      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cnt
        logic [HW-1:0] hold_count_reg;
        logic [HW-1:0] hold_count_next;

        always_comb begin
          hold_count_next = hold_count_reg;
          if (!state_reg[gi]) begin
            hold_count_next = '0;
          end else if (tick && (hold_count_reg != HOLD_MAX)) begin
            hold_count_next = hold_count_reg + HW'(1);
          end
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            hold_count_reg <= '0;
          end else begin
            hold_count_reg <= hold_count_next;
          end
        end

        // Gating with the level makes hold drop together with the fall strobe.
        assign hold_now[gi]  = state_reg[gi] && (hold_count_reg == HOLD_MAX);
        assign hold_next[gi] = state_next[gi] && (hold_count_next == HOLD_MAX);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_pulse_reg <= '0;
        end else begin
          hold_pulse_reg <= hold_next & ~hold_now;
        end
      end

      assign hold       = hold_now;
      assign hold_pulse = hold_pulse_reg;
    end else begin : g_no_hold
      assign hold       = '0;
      assign hold_pulse = '0;
    end
  endgenerate

endmodule

// File: tb/tb_debounce_switch_ev.sv
// Two debouncers (every-cycle sampling without long-press, and RATE=4 with an
// 8-tick long-press) share one random stimulus and are scored against a sample-based model.
module tb_debounce_switch_ev;

  localparam int W      = 3;
  localparam int NS     = 4;
  localparam int SY     = 2;
  localparam int RATE_A = 1;
  localparam int HOLD_A = 0;
  localparam int RATE_B = 4;
  localparam int HOLD_B = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in  = '0;

  logic [W-1:0] out_a, rise_a, fall_a, hold_a, hp_a;
  logic [W-1:0] out_b, rise_b, fall_b, hold_b, hp_b;

  always #5 clk = ~clk;

  debounce_switch_ev #(.WIDTH(W), .N(NS), .RATE(RATE_A), .SYNC_STAGES(SY), .HOLD_TICKS(HOLD_A)) dut_a (
    .clk(clk), .rst(rst), .in(in),
    .out(out_a), .rise(rise_a), .fall(fall_a), .hold(hold_a), .hold_pulse(hp_a)
  );

  debounce_switch_ev #(.WIDTH(W), .N(NS), .RATE(RATE_B), .SYNC_STAGES(SY), .HOLD_TICKS(HOLD_B)) dut_b (
    .clk(clk), .rst(rst), .in(in),
    .out(out_b), .rise(rise_b), .fall(fall_b), .hold(hold_b), .hold_pulse(hp_b)
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] hold;
    logic [W-1:0] hp;
  } rec_t;

  rec_t exp_q [2][$];

  int checks = 0;
  int errors = 0;

  // Reference model: last NS sampled values per channel, level, ticks spent high.
  logic [NS-1:0] win [2][W];
  logic          mo  [2][W];
  logic          mh  [2][W];
  int            mt  [2][W];
  int            pred_e = 0;
  int            mon_e  = 0;

  // Observations gathered by the monitor for the directed checks.
  int           first_rise_a     = -1;
  logic [W-1:0] first_rise_a_vec = '0;
  int           a_strobes        = 0;
  int           a_holdseen       = 0;
  int           b0_rise_cyc      = 0;
  int           b0_hp_cyc        = 0;
  int           b0_hp_cnt        = 0;
  int           b0_fall_hold     = 0;
  logic         b0_hold_prev     = 1'b0;

  function automatic int rate_of(input int d);
    return (d == 0) ? RATE_A : RATE_B;
  endfunction

  function automatic int hold_of(input int d);
    return (d == 0) ? HOLD_A : HOLD_B;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      for (int c = 0; c < W; c++) begin
        win[d][c] = '0;
        mo[d][c]  = 1'b0;
        mh[d][c]  = 1'b0;
        mt[d][c]  = 0;
      end
    end
    pred_e       = 0;
    mon_e        = 0;
    first_rise_a = -1;
  endtask

  // Called between clock edges; release lands 2 time units after a falling edge.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    model_clear();
    #1;
    chk("reset_outputs_a", 64'({out_a, rise_a, fall_a, hold_a, hp_a}), 64'd0);
    chk("reset_outputs_b", 64'({out_b, rise_b, fall_b, hold_b, hp_b}), 64'd0);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic apply(input logic [W-1:0] v, input int n);
    @(posedge clk);
    #1;
    in = v;
    repeat (n - 1) @(posedge clk);
  endtask

  // Predictor: the input seen at edge e is sampled at edge e+SY (if that edge
  // is a tick); the level decided from the samples shows one edge later.
  initial begin : predictor
    rec_t r;
    int   t;
    int   p;
    logic po;
    logic ph;
    forever begin
      @(posedge clk);
      if (!rst) begin
        pred_e++;
        for (int d = 0; d < 2; d++) begin
          t      = pred_e + SY;
          p      = t + 1;
          r.cyc  = p;
          r.out  = '0;
          r.rise = '0;
          r.fall = '0;
          r.hold = '0;
          r.hp   = '0;
          for (int c = 0; c < W; c++) begin
            po = mo[d][c];
            ph = mh[d][c];
            if (t % rate_of(d) == 0) win[d][c] = {win[d][c][NS-2:0], in[c]};
            if (win[d][c] == '1) mo[d][c] = 1'b1;
            else if (win[d][c] == '0) mo[d][c] = 1'b0;
            if (!mo[d][c] || !po) mt[d][c] = 0;
            else if (p % rate_of(d) == 0) mt[d][c]++;
            mh[d][c]  = (hold_of(d) > 0) && mo[d][c] && (mt[d][c] >= hold_of(d));
            r.out[c]  = mo[d][c];
            r.rise[c] = mo[d][c] & ~po;
            r.fall[c] = ~mo[d][c] & po;
            r.hold[c] = mh[d][c];
            r.hp[c]   = mh[d][c] & ~ph;
          end
          exp_q[d].push_back(r);
        end
      end
    end
  end

  // Monitor: every cycle out of reset the DUTs present a full output set.
  initial begin : monitor
    rec_t         r;
    logic [5*W-1:0] act;
    logic [5*W-1:0] req;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_e++;
        for (int d = 0; d < 2; d++) begin
          act = (d == 0) ? {out_a, rise_a, fall_a, hold_a, hp_a}
                         : {out_b, rise_b, fall_b, hold_b, hp_b};
          while (exp_q[d].size() > 0 && exp_q[d][0].cyc < mon_e) begin
            r = exp_q[d].pop_front();
            checks++;
            errors++;
            $display("FAIL stale_expect dut%0d: record for cycle %0d not consumed at cycle %0d", d, r.cyc, mon_e);
          end
          req = '0;
          if (exp_q[d].size() > 0 && exp_q[d][0].cyc == mon_e) begin
            r   = exp_q[d].pop_front();
            req = {r.out, r.rise, r.fall, r.hold, r.hp};
          end
          checks++;
          if (act !== req) begin
            errors++;
            $display("FAIL outputs dut%0d cycle %0d: got out=%b rise=%b fall=%b hold=%b hp=%b expected out=%b rise=%b fall=%b hold=%b hp=%b",
                     d, mon_e, act[5*W-1:4*W], act[4*W-1:3*W], act[3*W-1:2*W], act[2*W-1:W], act[W-1:0],
                     req[5*W-1:4*W], req[4*W-1:3*W], req[3*W-1:2*W], req[2*W-1:W], req[W-1:0]);
          end
        end
        if (rise_a != '0 && first_rise_a < 0) begin
          first_rise_a     = mon_e;
          first_rise_a_vec = rise_a;
        end
        if ((rise_a | fall_a) != '0) a_strobes++;
        if ((hold_a | hp_a) != '0) a_holdseen++;
        if (rise_b[0]) b0_rise_cyc = mon_e;
        if (hp_b[0]) begin
          b0_hp_cyc = mon_e;
          b0_hp_cnt++;
        end
        if (fall_b[0] && b0_hold_prev && !hold_b[0]) b0_fall_hold++;
        b0_hold_prev = hold_b[0];
      end
    end
  end

  initial begin : stimulus
    int hp_base;
    int fh_base;
    int a_base;
    int runl [W];

    // All inputs high through reset; rise must appear SY+NS+1 edges after release.
    in = '1;
    #23;
    do_reset(2);
    @(negedge clk);
    #1;
    chk("first_cycle_zero_a", 64'({out_a, rise_a, fall_a, hold_a, hp_a}), 64'd0);
    chk("first_cycle_zero_b", 64'({out_b, rise_b, fall_b, hold_b, hp_b}), 64'd0);
    repeat (12) @(negedge clk);
    chk("rise_latency_a", 64'(first_rise_a), 64'(SY + NS + 1));
    chk("rise_all_channels_a", 64'(first_rise_a_vec), 64'({W{1'b1}}));

    // Reset mid-filter (a few cycles after release).
    @(negedge clk);
    #3;
    do_reset(1);
    repeat (4) @(negedge clk);
    #3;
    do_reset(2);
    repeat (13) @(negedge clk);
    chk("rise_latency_a_after_pulse", 64'(first_rise_a), 64'(SY + NS + 1));

    // Reset mid-hold on the long-press instance.
    repeat (25) @(negedge clk);
    #3;
    do_reset(2);
    apply('1, 60);
    apply('0, 40);

    // Glitch train 1,1,1,0 on channel 0: never four equal samples at RATE=1.
    a_base = a_strobes;
    for (int k = 0; k < 12; k++) begin
      apply(3'b001, 3);
      apply(3'b000, 1);
    end
    @(negedge clk);
    chk("glitch_no_strobe_a", 64'(a_strobes - a_base), 64'd0);
    chk("glitch_out_a0", 64'(out_a[0]), 64'd0);
    apply('0, 30);

    // Long press on channel 0, then release.
    hp_base = b0_hp_cnt;
    fh_base = b0_fall_hold;
    apply(3'b001, 70);
    chk("long_press_pulse_count", 64'(b0_hp_cnt - hp_base), 64'd1);
    chk("long_press_delay_window",
        64'((b0_hp_cyc - b0_rise_cyc >= RATE_B * (HOLD_B - 1)) && (b0_hp_cyc - b0_rise_cyc <= RATE_B * HOLD_B)), 64'd1);
    apply('0, 30);
    chk("hold_drops_with_fall", 64'(b0_fall_hold - fh_base), 64'd1);

    // Short press (about 5 ticks of debounced high): no long-press.
    hp_base = b0_hp_cnt;
    apply(3'b001, 20);
    apply('0, 30);
    chk("short_press_no_pulse", 64'(b0_hp_cnt - hp_base), 64'd0);
    chk("short_press_no_hold", 64'(hold_b[0]), 64'd0);

    // Re-press: counter must restart from zero.
    hp_base = b0_hp_cnt;
    apply(3'b001, 70);
    chk("repress_pulse_count", 64'(b0_hp_cnt - hp_base), 64'd1);
    chk("repress_delay_window",
        64'((b0_hp_cyc - b0_rise_cyc >= RATE_B * (HOLD_B - 1)) && (b0_hp_cyc - b0_rise_cyc <= RATE_B * HOLD_B)), 64'd1);
    apply('0, 30);

    // Random run lengths mixing bounces and long presses.
    for (int c = 0; c < W; c++) runl[c] = 0;
    for (int k = 0; k < 2100; k++) begin
      if (k == 1500) begin
        @(negedge clk);
        #3;
        do_reset(3);
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < W; c++) begin
        if (runl[c] == 0) begin
          in[c]   = 1'($urandom_range(0, 1));
          runl[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 90)) : int'($urandom_range(1, 12));
        end else begin
          runl[c]--;
        end
      end
    end
    apply('0, 60);

    chk("hold_disabled_a", 64'(a_holdseen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
